// File: rtl/setter_pkg.sv
// rtl/setter_pkg.sv - shared timing defaults, counter-width helper and key event encoding for the value setter
package setter_pkg;

    localparam int DEB_CYC_DEF = 4;
    localparam int UPD_LEN_DEF = 8;
    localparam int REP_DLY_DEF = 16;
    localparam int REP_PER_DEF = 4;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_INC  = 2'd1,
        EV_DEC  = 2'd2
    } ev_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Opposing presses in the same cycle cancel out.
    function automatic ev_t to_event(input logic inc, input logic dec);
        if (inc && !dec) return EV_INC;
        if (dec && !inc) return EV_DEC;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one active-low key: 2-FF sync, debounce, press pulse, repeat under SETTER_AUTOREPEAT_EN
module key_debounce
    import setter_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int REP_DLY = REP_DLY_DEF,
    parameter int REP_PER = REP_PER_DEF,
    parameter bit REP_EN  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    localparam int DW = clog2(DEB_CYC);

    logic          s1, s2, stable;
    logic [DW-1:0] cnt;
    logic          accept, accept_low, rep_ev;

    assign accept     = (s2 != stable) && (cnt == DW'(DEB_CYC - 1));
    assign accept_low = accept && !s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

`ifdef SETTER_AUTOREPEAT_EN
    if (REP_EN) begin : g_rep
        localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
        localparam int RW   = clog2(RMAX);

        logic [RW-1:0] rep_cnt;
        logic          first;

        // First repeat waits REP_DLY after the press, later ones REP_PER apart.
        assign rep_ev = !stable && (first ? (rep_cnt == RW'(REP_DLY - 1))
                                          : (rep_cnt == RW'(REP_PER - 1)));

        always_ff @(posedge clk) begin
            if (!reset) begin
                rep_cnt <= '0;
                first   <= 1'b1;
            end else if (accept_low) begin
                rep_cnt <= '0;
                first   <= 1'b1;
            end else if (!stable) begin
                if (rep_ev) begin
                    rep_cnt <= '0;
                    first   <= 1'b0;
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end
        end
    end else begin : g_no_rep
        assign rep_ev = 1'b0;
    end
`else
    localparam bit REP_CFG = REP_EN && (REP_DLY > 0) && (REP_PER > 0);
    assign rep_ev = REP_CFG & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) press <= 1'b0;
        else        press <= accept_low | rep_ev;
    end

endmodule

// File: rtl/multi_channel_value_setter.sv
// rtl/multi_channel_value_setter.sv - NCH key-edited W-bit values with commit and update strobe; SETTER_AUTOREPEAT_EN enables key repeat
module multi_channel_value_setter
    import setter_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int W       = 4,
    parameter int INIT    = 2**W - 1,
    parameter int WRAP    = 1,
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int UPD_LEN = UPD_LEN_DEF,
    parameter int REP_DLY = REP_DLY_DEF,
    parameter int REP_PER = REP_PER_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   key_inc,
    input  logic [NCH-1:0]   key_dec,
    input  logic             key_commit,
    output logic [NCH*W-1:0] work,
    output logic [NCH*W-1:0] data,
    output logic             update,
    output logic             pending
);

    localparam logic [W-1:0] MAXV  = '1;
    localparam logic [W-1:0] INITV = W'(INIT);
    localparam int           UW    = clog2(UPD_LEN);

    logic [NCH-1:0] inc_ev, dec_ev;
    logic           commit_ev;
    logic [UW-1:0]  upd_cnt;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        key_debounce #(
            .DEB_CYC(DEB_CYC), .REP_DLY(REP_DLY), .REP_PER(REP_PER), .REP_EN(1'b1)
        ) u_inc (
            .clk(clk), .reset(reset), .key(key_inc[i]), .press(inc_ev[i])
        );
        key_debounce #(
            .DEB_CYC(DEB_CYC), .REP_DLY(REP_DLY), .REP_PER(REP_PER), .REP_EN(1'b1)
        ) u_dec (
            .clk(clk), .reset(reset), .key(key_dec[i]), .press(dec_ev[i])
        );
    end

    key_debounce #(
        .DEB_CYC(DEB_CYC), .REP_DLY(REP_DLY), .REP_PER(REP_PER), .REP_EN(1'b0)
    ) u_commit (
        .clk(clk), .reset(reset), .key(key_commit), .press(commit_ev)
    );

    function automatic logic [W-1:0] step(input logic [W-1:0] v, input ev_t ev);
        case (ev)
            EV_INC:  step = (v == MAXV) ? ((WRAP != 0) ? '0 : MAXV) : v + W'(1);
            EV_DEC:  step = (v == '0) ? ((WRAP != 0) ? MAXV : '0) : v - W'(1);
            default: step = v;
        endcase
    endfunction

    // data captures work as it stood before this edge, so same-cycle edits stay uncommitted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            work    <= {NCH{INITV}};
            data    <= {NCH{INITV}};
            update  <= 1'b0;
            upd_cnt <= '0;
            pending <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++)
                work[i*W +: W] <= step(work[i*W +: W], to_event(inc_ev[i], dec_ev[i]));
            if (commit_ev) begin
                data    <= work;
                update  <= 1'b1;
                upd_cnt <= UW'(UPD_LEN - 1);
            end else if (update) begin
                if (upd_cnt == '0) update  <= 1'b0;
                else               upd_cnt <= upd_cnt - UW'(1);
            end
            pending <= (work != data);
        end
    end

endmodule

// File: tb/tb_multi_channel_value_setter.sv
// tb/tb_multi_channel_value_setter.sv - vector table, corner sequences and randomized model check of the value setter
module tb_multi_channel_value_setter;

    localparam int NCH = 2;
    localparam int W   = 4;
`ifdef SETTER_AUTOREPEAT_EN
    localparam int N_REP_EXP = 7;
`else
    localparam int N_REP_EXP = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NCH-1:0] ki = '1, kd = '1, k_idle = '1;
    logic kc = 1'b1, kc_f = 1'b1;
    logic [NCH*W-1:0] work, data, work_s, data_s, work_f, data_f;
    logic update, pending, update_s, pending_s, update_f, pending_f;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    multi_channel_value_setter dut (
        .clk(clk), .reset(reset), .key_inc(ki), .key_dec(kd), .key_commit(kc),
        .work(work), .data(data), .update(update), .pending(pending)
    );

    multi_channel_value_setter #(.WRAP(0)) u_sat (
        .clk(clk), .reset(reset), .key_inc(ki), .key_dec(kd), .key_commit(kc),
        .work(work_s), .data(data_s), .update(update_s), .pending(pending_s)
    );

    multi_channel_value_setter #(.DEB_CYC(1)) u_fast (
        .clk(clk), .reset(reset), .key_inc(k_idle), .key_dec(k_idle), .key_commit(kc_f),
        .work(work_f), .data(data_f), .update(update_f), .pending(pending_f)
    );

    typedef struct {
        logic [NCH-1:0] inc;
        logic [NCH-1:0] dec;
        logic           cm;
        int             hold;
        logic [7:0]     ew, ed, es, eds;
        logic           ep;
    } vec_t;

    vec_t tv[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic press(input logic [NCH-1:0] inc, input logic [NCH-1:0] dec,
                         input logic cm, input int hold);
        ki = ~inc;
        kd = ~dec;
        kc = ~cm;
        repeat (hold) @(negedge clk);
        ki = '1;
        kd = '1;
        kc = 1'b1;
        repeat (14) @(negedge clk);
    endtask

    function automatic logic [7:0] pk(input int lo, input int hi);
        logic [3:0] l, h;
        l = lo[3:0];
        h = hi[3:0];
        return {h, l};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int hi, gaps, prev, found, k;
        int mw[NCH], ms[NCH], md[NCH], mds[NCH];
        logic [NCH-1:0] r_inc, r_dec;
        logic r_cm;

        tv[0] = '{2'b01, 2'b00, 1'b0, 12, 8'hF0, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        tv[1] = '{2'b00, 2'b10, 1'b0,  2, 8'hF0, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        tv[2] = '{2'b00, 2'b10, 1'b0,  6, 8'hE0, 8'hFF, 8'hEF, 8'hFF, 1'b1};
        tv[3] = '{2'b00, 2'b01, 1'b0,  8, 8'hEF, 8'hFF, 8'hEE, 8'hFF, 1'b1};
        tv[4] = '{2'b00, 2'b00, 1'b1,  8, 8'hEF, 8'hEF, 8'hEE, 8'hEE, 1'b0};
        tv[5] = '{2'b11, 2'b01, 1'b0,  8, 8'hFF, 8'hEF, 8'hFE, 8'hEE, 1'b1};
        tv[6] = '{2'b10, 2'b00, 1'b0,  8, 8'h0F, 8'hEF, 8'hFE, 8'hEE, 1'b1};
        tv[7] = '{2'b00, 2'b01, 1'b1,  8, 8'h0E, 8'h0F, 8'hFD, 8'hFE, 1'b1};
        tv[8] = '{2'b01, 2'b00, 1'b0,  8, 8'h0F, 8'h0F, 8'hFE, 8'hFE, 1'b0};

        do_reset();
        check("rst_work", work, 8'hFF);
        check("rst_data", data, 8'hFF);
        check("rst_update", update, 0);
        check("rst_pending", pending, 0);
        check("rst_sat_work", work_s, 8'hFF);
        check("rst_sat_data", data_s, 8'hFF);
        check("rst_sat_flags", {update_s, pending_s}, 0);
        check("rst_fast_work", work_f, 8'hFF);
        check("rst_fast_data", data_f, 8'hFF);
        check("rst_fast_flags", {update_f, pending_f}, 0);

        for (int i = 0; i < 9; i++) begin
            press(tv[i].inc, tv[i].dec, tv[i].cm, tv[i].hold);
            check($sformatf("vec%0d_work", i), work, tv[i].ew);
            check($sformatf("vec%0d_data", i), data, tv[i].ed);
            check($sformatf("vec%0d_pending", i), pending, tv[i].ep);
            check($sformatf("vec%0d_sat_work", i), work_s, tv[i].es);
            check($sformatf("vec%0d_sat_data", i), data_s, tv[i].eds);
        end

        // Commit strobe length and pending clear.
        press(2'b10, 2'b00, 1'b0, 8);
        check("pre_commit_work", work, 8'h1F);
        check("pre_commit_pending", pending, 1);
        kc = 1'b0;
        hi = 0; gaps = 0; prev = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (update && !prev && hi > 0) gaps++;
            if (update) hi++;
            prev = update;
            if (k == 8) kc = 1'b1;
        end
        check("strobe_len", hi, 8);
        check("strobe_gaps", gaps, 0);
        check("commit_data", data, 8'h1F);
        check("post_commit_pending", pending, 0);

        // Second commit on strobe cycle 5 extends the strobe without a gap.
        kc_f = 1'b0;
        hi = 0; gaps = 0; prev = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (update_f && !prev && hi > 0) gaps++;
            if (update_f) hi++;
            prev = update_f;
            if (k == 2) kc_f = 1'b1;
            if (k == 5) kc_f = 1'b0;
            if (k == 7) kc_f = 1'b1;
        end
        check("ext_strobe_len", hi, 13);
        check("ext_strobe_gaps", gaps, 0);

        // Reset on strobe cycle 3 aborts everything.
        kc = 1'b0;
        found = 0;
        for (k = 0; k < 30 && found == 0; k++) begin
            @(negedge clk);
            if (update) found = 1;
        end
        check("strobe_start_seen", found, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        kc = 1'b1;
        @(negedge clk);
        check("midstrobe_rst_update", update, 0);
        check("midstrobe_rst_data", data, 8'hFF);
        check("midstrobe_rst_work", work, 8'hFF);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Long hold: repeat count depends on the build.
        ki[0] = 1'b0;
        found = 0;
        for (k = 0; k < 30 && found == 0; k++) begin
            @(negedge clk);
            if (work[3:0] != 4'hF) found = 1;
        end
        check("hold_first_event_seen", found, 1);
        repeat (31) @(negedge clk);
        ki[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("hold_work", work, pk((15 + N_REP_EXP) % 16, 15));
        check("hold_sat_work", work_s, 8'hFF);

        // Randomized presses against an arithmetic model of both instances.
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            mw[c] = 15; ms[c] = 15; md[c] = 15; mds[c] = 15;
        end
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                k = $urandom_range(0, 2 * NCH);
                if (k < NCH) ki[k] = 1'b0;
                else if (k < 2 * NCH) kd[k - NCH] = 1'b0;
                else kc = 1'b0;
                repeat (2) @(negedge clk);
                ki = '1; kd = '1; kc = 1'b1;
                repeat (10) @(negedge clk);
            end else begin
                r_inc = NCH'($urandom_range(0, 3));
                r_dec = NCH'($urandom_range(0, 3));
                r_cm  = ($urandom_range(0, 3) == 0);
                if (r_cm) begin
                    for (int c = 0; c < NCH; c++) begin
                        md[c] = mw[c];
                        mds[c] = ms[c];
                    end
                end
                for (int c = 0; c < NCH; c++) begin
                    if (r_inc[c] && !r_dec[c]) begin
                        mw[c] = (mw[c] + 1) % 16;
                        ms[c] = (ms[c] == 15) ? 15 : ms[c] + 1;
                    end else if (r_dec[c] && !r_inc[c]) begin
                        mw[c] = (mw[c] + 15) % 16;
                        ms[c] = (ms[c] == 0) ? 0 : ms[c] - 1;
                    end
                end
                press(r_inc, r_dec, r_cm, $urandom_range(6, 11));
            end
            check($sformatf("rnd%0d_work", t), work, pk(mw[0], mw[1]));
            check($sformatf("rnd%0d_data", t), data, pk(md[0], md[1]));
            check($sformatf("rnd%0d_pending", t), pending,
                  (pk(mw[0], mw[1]) != pk(md[0], md[1])) ? 1 : 0);
            check($sformatf("rnd%0d_sat_work", t), work_s, pk(ms[0], ms[1]));
            check($sformatf("rnd%0d_sat_data", t), data_s, pk(mds[0], mds[1]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
